cluster_dma_frontend_arbiter: RTL and testbench

Sits between the per-PE DMA frontend register files and the DMA backend stream(s). Round-robin arbitrates the descriptor launch requests from all PEs and selects a target backend stream. Registers each granted descriptor into a per-stream output stage. Owns the per-stream 28-bit transfer-ID counters (next_id/done_id) and the busy status that the register files expose to software.

---
 rtl/cluster_dma_pkg.sv | 33 +++
 rtl/cluster_dma_frontend_arbiter_if.sv | 34 +++
 rtl/cluster_dma_stream_tracker.sv | 88 ++++++++
 rtl/cluster_dma_frontend_arbiter.sv | 124 ++++++++++++
 tb/tb_cluster_dma_frontend_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_dma_pkg.sv
// Shared types and constants for the cluster DMA frontend: descriptor layout,
// transfer-ID width and the frontend register map.
package cluster_dma_pkg;

    localparam int unsigned TransferIdWidth = 28;
    localparam int unsigned AddrWidth       = 32;

    typedef logic [TransferIdWidth-1:0] transf_id_t;

    typedef struct packed {
        logic [31:0]          num_bytes;
        logic [AddrWidth-1:0] dst_addr;
        logic [AddrWidth-1:0] src_addr;
        logic                 decouple;
        logic                 deburst;
        logic                 serialize;
    } transf_descr_t;

    // Byte offsets of the per-PE frontend register file
    localparam logic [7:0] RegSrcAddr  = 8'h00;
    localparam logic [7:0] RegDstAddr  = 8'h08;
    localparam logic [7:0] RegNumBytes = 8'h10;
    localparam logic [7:0] RegConf     = 8'h18;
    localparam logic [7:0] RegStatus   = 8'h20;
    localparam logic [7:0] RegNextId   = 8'h28;
    localparam logic [7:0] RegDoneId   = 8'h30;

    // Width of an index into n items; a single item still needs one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cluster_dma_frontend_arbiter_if.sv
// Bundle of the PE launch ports and backend stream ports of the arbiter.
// The arbiter uses the slave view; PEs/backend (or a bench) use the master view.
interface cluster_dma_frontend_arbiter_if
    import cluster_dma_pkg::*;
#(
    parameter int unsigned NumPe      = 8,
    parameter int unsigned NumStreams = 1
);

    localparam int unsigned IdxWidth = idx_width(NumStreams);

    logic          [NumPe-1:0]      pe_valid;
    logic          [NumPe-1:0]      pe_ready;
    transf_descr_t [NumPe-1:0]      pe_descr;
    transf_id_t    [NumStreams-1:0] next_id;
    transf_id_t    [NumStreams-1:0] done_id;
    logic          [IdxWidth-1:0]   be_sel;
    logic                           be_busy;
    logic          [NumStreams-1:0] be_valid;
    logic          [NumStreams-1:0] be_ready;
    transf_descr_t [NumStreams-1:0] be_descr;
    logic          [NumStreams-1:0] be_done;

    modport slave (
        input  pe_valid, pe_descr, be_ready, be_done,
        output pe_ready, next_id, done_id, be_sel, be_busy, be_valid, be_descr
    );

    modport master (
        output pe_valid, pe_descr, be_ready, be_done,
        input  pe_ready, next_id, done_id, be_sel, be_busy, be_valid, be_descr
    );

endinterface

// File: rtl/cluster_dma_stream_tracker.sv
// Per-stream state: one-entry output stage towards the backend, the
// next/done transfer-ID counters and the count of launched-but-not-done
// transfers. Accepts a new launch only while eligible is high.
module cluster_dma_stream_tracker
    import cluster_dma_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load,
    input  transf_descr_t load_descr,
    input  logic          ready,
    input  logic          done,
    output logic          valid,
    output transf_descr_t descr,
    output transf_id_t    next_id,
    output transf_id_t    done_id,
    output logic          eligible,
    output logic          busy
);

    localparam int unsigned     CntWidth = $clog2(MaxOutstanding + 1);
    localparam [CntWidth-1:0]   MaxCnt   = CntWidth'(MaxOutstanding);

    logic                valid_q;
    transf_descr_t       descr_q;
    transf_id_t          next_id_q;
    transf_id_t          done_id_q;
    logic [CntWidth-1:0] outstanding_q;
    logic                done_ok;

    // A completion only counts if a transfer is actually in flight
    assign done_ok  = done && (outstanding_q != '0);
    assign eligible = (!valid_q || ready) && (outstanding_q < MaxCnt);
    assign busy     = valid_q || (outstanding_q != '0);

    assign valid    = valid_q;
    assign descr    = descr_q;
    assign next_id  = next_id_q;
    assign done_id  = done_id_q;

    // Output stage occupancy: a load wins over a drain so both can coincide
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (ready) begin
            valid_q <= 1'b0;
        end
    end

    // Output stage payload
    // NOTE: payload flops carry no reset; their content is only meaningful while valid_q is set.
    always_ff @(posedge clk_i) begin
        if (load) begin
            descr_q <= load_descr;
        end
    end

    // Transfer-ID counters (28-bit wrap) and outstanding count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            next_id_q     <= transf_id_t'(1);
            done_id_q     <= '0;
            outstanding_q <= '0;
        end else begin
            if (load) begin
                next_id_q <= next_id_q + 1'b1;
            end
            if (done_ok) begin
                done_id_q <= done_id_q + 1'b1;
            end
            case ({load, done_ok})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // A completion with nothing in flight is a backend protocol error
    assert property (@(posedge clk_i) disable iff (!rst_ni) done |-> (outstanding_q != '0))
        else $error("stream tracker: done pulse with no outstanding transfer");

endmodule

// File: rtl/cluster_dma_frontend_arbiter.sv
// Round-robin launch arbiter between the per-PE DMA register files and the
// backend streams. The winning PE's descriptor is loaded into the lowest
// eligible stream in the grant cycle; per-stream trackers own the IDs.
module cluster_dma_frontend_arbiter
    import cluster_dma_pkg::*;
#(
    parameter int unsigned NumPe          = 8,
    parameter int unsigned NumStreams     = 1,
    parameter int unsigned MaxOutstanding = 16
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    cluster_dma_frontend_arbiter_if.slave bus
);

    localparam int unsigned IdxWidth   = idx_width(NumStreams);
    localparam int unsigned PeIdxWidth = idx_width(NumPe);

    typedef logic [IdxWidth-1:0]   idx_t;
    typedef logic [PeIdxWidth-1:0] pe_idx_t;

    logic [NumStreams-1:0] eligible;
    logic [NumStreams-1:0] busy;
    logic [NumStreams-1:0] load;
    logic [NumPe-1:0]      grant;
    logic                  any_eligible;
    logic                  any_valid;
    logic                  handshake;
    logic                  found_hi;
    logic                  found_lo;
    idx_t                  sel;
    idx_t                  sel_q;
    pe_idx_t               rr_q;
    pe_idx_t               rr_next;
    pe_idx_t               win_hi;
    pe_idx_t               win_lo;
    pe_idx_t               winner;
    logic                  busy_q;

    // Lowest-index eligible stream, else hold the last selection
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        sel          = sel_q;
        any_eligible = 1'b0;
        for (int s = NumStreams - 1; s >= 0; s--) begin
            if (eligible[s]) begin
                sel          = idx_t'(s);
                any_eligible = 1'b1;
            end
        end
    end

    // Round robin: first requester at or above the pointer, else the first below it
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = rr_q;
        win_lo   = rr_q;
        for (int i = NumPe - 1; i >= 0; i--) begin
            if (bus.pe_valid[i]) begin
                if (pe_idx_t'(i) >= rr_q) begin
                    win_hi   = pe_idx_t'(i);
                    found_hi = 1'b1;
                end else begin
                    win_lo   = pe_idx_t'(i);
                    found_lo = 1'b1;
                end
            end
        end
        winner    = found_hi ? win_hi : win_lo;
        any_valid = found_hi || found_lo;
        handshake = any_valid && any_eligible;
        rr_next   = (winner == pe_idx_t'(NumPe - 1)) ? '0 : winner + 1'b1;
    end

    // One-hot grant towards the winning PE, only when a stream can take it
    always_comb begin
        grant = '0;
        if (handshake) begin
            grant[winner] = 1'b1;
        end
    end

    assign bus.pe_ready = grant;
    assign bus.be_sel   = sel;
    assign bus.be_busy  = busy_q;

    for (genvar s = 0; s < NumStreams; s++) begin : gen_stream
        assign load[s] = handshake && (sel == idx_t'(s));

        cluster_dma_stream_tracker #(
            .MaxOutstanding(MaxOutstanding)
        ) u_tracker (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load       (load[s]),
            .load_descr (bus.pe_descr[winner]),
            .ready      (bus.be_ready[s]),
            .done       (bus.be_done[s]),
            .valid      (bus.be_valid[s]),
            .descr      (bus.be_descr[s]),
            .next_id    (bus.next_id[s]),
            .done_id    (bus.done_id[s]),
            .eligible   (eligible[s]),
            .busy       (busy[s])
        );
    end

    // Round-robin pointer, last stream selection and registered busy status
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            sel_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            if (handshake) begin
                rr_q <= rr_next;
            end
            sel_q  <= sel;
            busy_q <= |busy;
        end
    end

endmodule

// File: tb/tb_cluster_dma_frontend_arbiter.sv
// Self-checking bench: a single-stream instance driven by directed and random
// steps against a transaction-level model, plus a two-stream instance checked
// with directed expectations.
module tb_cluster_dma_frontend_arbiter;
    import cluster_dma_pkg::*;

    localparam int NP   = 8;
    localparam int MAXO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst2_n;

    cluster_dma_frontend_arbiter_if #(.NumPe(NP), .NumStreams(1)) bus1 ();
    cluster_dma_frontend_arbiter_if #(.NumPe(NP), .NumStreams(2)) bus2 ();

    cluster_dma_frontend_arbiter #(.NumPe(NP), .NumStreams(1), .MaxOutstanding(MAXO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    cluster_dma_frontend_arbiter #(.NumPe(NP), .NumStreams(2), .MaxOutstanding(MAXO)) dut2 (
        .clk_i  (clk),
        .rst_ni (rst2_n),
        .bus    (bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the single-stream instance
    transf_id_t    m_next;
    transf_id_t    m_done;
    int            m_out;
    logic          m_sv;
    transf_descr_t m_sd;
    int            m_rr;
    logic          m_busy;

    // Stimulus for the single-stream instance
    logic [NP-1:0] pv;
    transf_descr_t pd [NP];
    logic          br;
    logic          bd;
    int            last_grant;
    transf_id_t    last_id;

    int            order [5] = '{1, 3, 5, 1, 3};
    transf_descr_t held;
    transf_descr_t da;
    transf_descr_t db;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic transf_descr_t rand_descr();
        transf_descr_t d;
        d.num_bytes = $urandom;
        d.dst_addr  = $urandom;
        d.src_addr  = $urandom;
        d.decouple  = 1'($urandom);
        d.deburst   = 1'($urandom);
        d.serialize = 1'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        m_next = transf_id_t'(1);
        m_done = '0;
        m_out  = 0;
        m_sv   = 1'b0;
        m_rr   = 0;
        m_busy = 1'b0;
    endtask

    // One cycle on the single-stream instance: drive at the falling edge,
    // compare against the model, then advance the model at the rising edge.
    task automatic step();
        bit            elig;
        int            win;
        logic [NP-1:0] exp_ready;
        bit            hs;
        bit            dok;
        bit            busy_n;
        bus1.pe_valid = pv;
        for (int i = 0; i < NP; i++) bus1.pe_descr[i] = pd[i];
        bus1.be_ready = br;
        bus1.be_done  = bd;
        #1;
        elig = (!m_sv || br) && (m_out < MAXO);
        win  = -1;
        for (int k = 0; k < NP; k++) begin
            if (win < 0 && pv[(m_rr + k) % NP]) win = (m_rr + k) % NP;
        end
        exp_ready = '0;
        if (elig && win >= 0) exp_ready[win] = 1'b1;
        check("pe_ready", 128'(bus1.pe_ready), 128'(exp_ready));
        check("be_sel", 128'(bus1.be_sel), 128'(0));
        check("be_valid", 128'(bus1.be_valid), 128'(m_sv));
        if (m_sv) check("be_descr", 128'(bus1.be_descr[0]), 128'(m_sd));
        check("next_id", 128'(bus1.next_id[0]), 128'(m_next));
        check("done_id", 128'(bus1.done_id[0]), 128'(m_done));
        check("be_busy", 128'(bus1.be_busy), 128'(m_busy));
        hs         = (exp_ready != '0);
        dok        = bd && (m_out > 0);
        busy_n     = (m_out != 0) || m_sv;
        last_grant = hs ? win : -1;
        last_id    = m_next;
        @(posedge clk);
        if (hs) begin
            m_sv   = 1'b1;
            m_sd   = pd[win];
            m_next = m_next + 1'b1;
            m_rr   = (win + 1) % NP;
        end else if (br) begin
            m_sv = 1'b0;
        end
        m_out = m_out + (hs ? 1 : 0) - (dok ? 1 : 0);
        if (dok) m_done = m_done + 1'b1;
        m_busy = busy_n;
        @(negedge clk);
    endtask

    task automatic drain_all();
        pv = '0;
        br = 1'b1;
        while (m_out > 0) begin
            bd = 1'b1;
            step();
        end
        bd = 1'b0;
        step();
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        pv = '0;
        br = 1'b0;
        bd = 1'b0;
        for (int i = 0; i < NP; i++) pd[i] = rand_descr();
        bus1.pe_valid = '0;
        bus1.be_ready = '0;
        bus1.be_done  = '0;
        bus2.pe_valid = '0;
        bus2.be_ready = '0;
        bus2.be_done  = '0;
        for (int i = 0; i < NP; i++) bus2.pe_descr[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        // Single launch from PE0, then completion
        pd[0].num_bytes = 32'd64;
        pv = 8'h01;
        br = 1'b1;
        step();
        check("pe0_grant", 128'(last_grant), 128'(0));
        check("pe0_id", 128'(last_id), 128'(1));
        pv = '0;
        step();
        step();
        bd = 1'b1;
        step();
        bd = 1'b0;
        check("pe0_done_id", 128'(bus1.done_id[0]), 128'(1));
        step();
        step();
        check("busy_clear", 128'(bus1.be_busy), 128'(0));

        // Three PEs requesting continuously: one grant per cycle in RR order
        pv = 8'b0010_1010;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_order", 128'(last_grant), 128'(order[i]));
        end
        drain_all();

        // Backpressure on the output stage
        pv = 8'b0001_0100;
        br = 1'b0;
        step();
        check("bp_first_grant", 128'(last_grant >= 0), 128'(1));
        held = m_sd;
        step();
        check("bp_stall", 128'(last_grant), 128'(-1));
        step();
        check("bp_descr_stable", 128'(bus1.be_descr[0]), 128'(held));
        br = 1'b1;
        step();
        check("bp_release_grant", 128'(last_grant >= 0), 128'(1));
        drain_all();

        // Outstanding limit
        pv = '1;
        br = 1'b1;
        for (int i = 0; i < MAXO; i++) begin
            pd[i % NP] = rand_descr();
            step();
            check("limit_fill", 128'(last_grant >= 0), 128'(1));
        end
        step();
        check("limit_stall", 128'(last_grant), 128'(-1));
        bd = 1'b1;
        step();
        check("limit_stall_on_done", 128'(last_grant), 128'(-1));
        bd = 1'b0;
        step();
        check("limit_release", 128'(last_grant >= 0), 128'(1));
        drain_all();

        // 28-bit ID wrap
        force dut.gen_stream[0].u_tracker.next_id_q = 28'hFFF_FFFF;
        force dut.gen_stream[0].u_tracker.done_id_q = 28'hFFF_FFFE;
        #1;
        release dut.gen_stream[0].u_tracker.next_id_q;
        release dut.gen_stream[0].u_tracker.done_id_q;
        m_next = 28'hFFF_FFFF;
        m_done = 28'hFFF_FFFE;
        pv = 8'h40;
        step();
        check("wrap_id_max", 128'(last_id), 128'(28'hFFF_FFFF));
        pv = 8'h02;
        step();
        check("wrap_id_zero", 128'(last_id), 128'(0));
        pv = '0;
        step();
        check("wrap_next_id", 128'(bus1.next_id[0]), 128'(1));
        bd = 1'b1;
        step();
        check("wrap_done_max", 128'(bus1.done_id[0]), 128'(28'hFFF_FFFF));
        step();
        check("wrap_done_zero", 128'(bus1.done_id[0]), 128'(0));
        bd = 1'b0;
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            pv = NP'($urandom);
            for (int i = 0; i < NP; i++) pd[i] = rand_descr();
            br = ($urandom_range(0, 3) != 0);
            bd = (m_out > 0) && ($urandom_range(0, 2) == 0);
            step();
        end
        drain_all();

        // Two streams: stream 0 stalled, launches move to stream 1
        da = rand_descr();
        db = rand_descr();
        check("s2_reset_next0", 128'(bus2.next_id[0]), 128'(1));
        check("s2_reset_next1", 128'(bus2.next_id[1]), 128'(1));
        bus2.be_ready = 2'b10;
        bus2.pe_valid = 8'h01;
        bus2.pe_descr[0] = da;
        #1;
        check("s2_first_ready", 128'(bus2.pe_ready), 128'(8'h01));
        check("s2_first_sel", 128'(bus2.be_sel), 128'(0));
        @(negedge clk);
        bus2.pe_valid = 8'h02;
        bus2.pe_descr[1] = db;
        #1;
        check("s2_sel_stream1", 128'(bus2.be_sel), 128'(1));
        check("s2_ready_pe1", 128'(bus2.pe_ready), 128'(8'h02));
        check("s2_id_stream1", 128'(bus2.next_id[1]), 128'(1));
        @(negedge clk);
        check("s2_valid_both", 128'(bus2.be_valid), 128'(2'b11));
        check("s2_descr0", 128'(bus2.be_descr[0]), 128'(da));
        check("s2_descr1", 128'(bus2.be_descr[1]), 128'(db));
        check("s2_next0", 128'(bus2.next_id[0]), 128'(2));
        // Launch and done on stream 1 in the same cycle
        bus2.pe_valid = 8'h04;
        bus2.be_done  = 2'b10;
        #1;
        check("s2_ld_ready", 128'(bus2.pe_ready), 128'(8'h04));
        check("s2_ld_sel", 128'(bus2.be_sel), 128'(1));
        @(negedge clk);
        bus2.be_done = 2'b00;
        check("s2_ld_outstanding", 128'(dut2.gen_stream[1].u_tracker.outstanding_q), 128'(1));
        check("s2_ld_done_id", 128'(bus2.done_id[1]), 128'(1));
        check("s2_ld_next_id", 128'(bus2.next_id[1]), 128'(3));
        // Nothing eligible: select holds, no grant
        bus2.be_ready = 2'b00;
        bus2.pe_valid = 8'h08;
        #1;
        check("s2_none_ready", 128'(bus2.pe_ready), 128'(0));
        check("s2_none_sel", 128'(bus2.be_sel), 128'(1));
        check("s2_busy", 128'(bus2.be_busy), 128'(1));
        // Reset in the middle of activity
        bus2.pe_valid = '0;
        rst2_n = 1'b0;
        #1;
        check("s2_rst_next0", 128'(bus2.next_id[0]), 128'(1));
        check("s2_rst_next1", 128'(bus2.next_id[1]), 128'(1));
        check("s2_rst_done0", 128'(bus2.done_id[0]), 128'(0));
        check("s2_rst_done1", 128'(bus2.done_id[1]), 128'(0));
        check("s2_rst_valid", 128'(bus2.be_valid), 128'(0));
        check("s2_rst_busy", 128'(bus2.be_busy), 128'(0));
        check("s2_rst_sel", 128'(bus2.be_sel), 128'(0));
        check("s2_rst_ready", 128'(bus2.pe_ready), 128'(0));
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        check("s2_post_rst_valid", 128'(bus2.be_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
